// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter.
//   state_t             : arbiter FSM states (IDLE, BUSY, ACK)
//   DEPTH_WORDS_DEFAULT : default number of 32-bit words in the data memory
//   WORD_ADDR_W         : width of the word index taken from a byte address
package mem_arbiter_pkg;

  localparam int DEPTH_WORDS_DEFAULT = 18;
  localparam int WORD_ADDR_W         = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick.
//   req0, req1 : pending requests
//   last       : id of the requester served most recently
//   grant      : id of the winner (meaningful only when any = 1)
//   any        : at least one request is pending
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic any
);

  // A lone requester wins outright; on a tie the one not served last wins.
  always_comb begin
    grant = 1'b0;
    any   = req0 | req1;
    if (req0 && req1) begin
      grant = ~last;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter that shares a single-port data memory between two requesters.
// Each access runs IDLE -> BUSY -> ACK, with one access in flight at a time.
//   clk, reset            : system clock, synchronous active-high reset
//   req0/1, we0/1         : request (held until ack) and write select
//   addr0/1, wdata0/1     : byte address and write data
//   ack0/1, err0/1        : one-cycle completion pulse, out-of-range flag
//   rdata0/1              : per-requester registered read data
//   mem_we, mem_a, mem_wd : memory write enable, word-aligned address, data
//   mem_rd                : combinational read data from the memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  state_t state, state_next;

  logic        win_id;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        last_served;
  logic        err_q;

  logic        grant;
  logic        any_req;
  logic        in_range;
  logic [31:0] rd_capture;
  logic [WORD_ADDR_W-1:0] word_idx;

  rr_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last_served),
    .grant (grant),
    .any   (any_req)
  );

  assign word_idx   = lat_addr[31:2];
  assign in_range   = ({2'b00, word_idx} < 32'(DEPTH_WORDS));
  assign rd_capture = in_range ? mem_rd : 32'h0;

  // The two low address bits are masked rather than dropped so the
  // latched address register stays a plain copy of the request.
  assign mem_a  = {lat_addr[31:2], lat_addr[1:0] & 2'b00};
  assign mem_wd = lat_wdata;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and outputs. Reset gates mem_we combinationally so a write
  // caught mid-BUSY never reaches the memory.
  always_comb begin
    state_next = state;
    ack0       = 1'b0;
    ack1       = 1'b0;
    err0       = 1'b0;
    err1       = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_next = BUSY;
      end
      BUSY: begin
        mem_we     = lat_we & in_range & ~reset;
        state_next = ACK;
      end
      ACK: begin
        ack0       = ~win_id;
        ack1       = win_id;
        err0       = ~win_id & err_q;
        err1       = win_id & err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch the winner in IDLE, capture read data and the range
  // result at the end of BUSY, remember who was served once acked.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_id      <= 1'b0;
      lat_we      <= 1'b0;
      lat_addr    <= 32'h0;
      lat_wdata   <= 32'h0;
      last_served <= 1'b1;
      err_q       <= 1'b0;
      rdata0      <= 32'h0;
      rdata1      <= 32'h0;
    end else begin
      if (state == IDLE && any_req) begin
        win_id    <= grant;
        lat_we    <= grant ? we1 : we0;
        lat_addr  <= grant ? addr1 : addr0;
        lat_wdata <= grant ? wdata1 : wdata0;
      end
      if (state == BUSY) begin
        err_q <= ~in_range;
        if (!lat_we) begin
          if (win_id) rdata1 <= rd_capture;
          else        rdata0 <= rd_capture;
        end
      end
      if (state == ACK) begin
        last_served <= win_id;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of single accesses checked
// through an ack-driven scoreboard, plus hand sequences for contention,
// dropped requests and reset during a write.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] bmem [64] = '{default: 32'h0};

  int checks   = 0;
  int failures = 0;
  int ackTotal = 0;
  int memWeCnt = 0;
  bit monOn    = 1'b0;

  typedef struct {
    bit          id;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[12];

  mem_arbiter #(.DEPTH_WORDS(18)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write on the clock edge.
  assign mem_rd = bmem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) bmem[mem_a[7:2]] <= mem_wd;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops an expectation on every ack and checks each
  // memory write against the in-flight transaction.
  always @(negedge clk) begin
    if (monOn) begin
      checkOutput("err0_without_ack", 32'(err0 & ~ack0), 32'h0);
      checkOutput("err1_without_ack", 32'(err1 & ~ack1), 32'h0);
      if (mem_we) begin
        memWeCnt++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_mem_we", 32'(mem_we), 32'h0);
        end else begin
          checkOutput("mem_we_allowed", 32'(sb[0].we & ~sb[0].err), 32'h1);
          checkOutput("mem_a", mem_a, {sb[0].addr[31:2], 2'b00});
          checkOutput("mem_wd", mem_wd, sb[0].wdata);
        end
      end
      if (ack0 || ack1) begin
        ackTotal++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_ack", 32'({ack1, ack0}), 32'h0);
        end else begin
          vec_t e;
          e = sb.pop_front();
          checkOutput("ack_pair", 32'({ack1, ack0}), e.id ? 32'h2 : 32'h1);
          checkOutput("err", 32'(e.id ? err1 : err0), 32'(e.err));
          checkOutput("rdata", e.id ? rdata1 : rdata0, e.rdata);
        end
      end
    end
  end

  task automatic doReset();
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic driveReq(input bit id, input bit val);
    if (id) req1 = val;
    else    req0 = val;
  endtask

  // Issues one access from IDLE (called just after a clock edge), waits a
  // bounded time for its ack and checks latency and write-enable count.
  task automatic applyStimulus(input vec_t v);
    int  cyc;
    bit  got;
    sb.push_back(v);
    memWeCnt = 0;
    if (v.id) begin we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
    else      begin we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
    driveReq(v.id, 1'b1);
    cyc = 0;
    got = 0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (v.id ? ack1 : ack0) got = 1;
    end
    checkOutput("ack_latency", 32'(cyc), got ? 32'd3 : 32'd99);
    @(posedge clk);
    #1 driveReq(v.id, 1'b0);
    checkOutput("mem_we_cycles", 32'(memWeCnt), 32'(v.we & ~v.err));
  endtask

  initial begin
    int startAcks;
    int cyc, lastAck, nAcks;
    bit expId;

    //        id  we  addr           wdata          err rdata
    vecs[0]  = '{0, 1, 32'h0000_0008, 32'hDEAD_BEEF, 0, 32'h0000_0000};
    vecs[1]  = '{0, 0, 32'h0000_0008, 32'h0,         0, 32'hDEAD_BEEF};
    vecs[2]  = '{1, 1, 32'h0000_0044, 32'hA5A5_0F0F, 0, 32'h0000_0000};
    vecs[3]  = '{1, 0, 32'h0000_0044, 32'h0,         0, 32'hA5A5_0F0F};
    vecs[4]  = '{1, 1, 32'h0000_0048, 32'h1111_2222, 1, 32'hA5A5_0F0F};
    vecs[5]  = '{0, 0, 32'h0000_0000, 32'h0,         0, 32'h0000_0000};
    vecs[6]  = '{1, 0, 32'h0000_0048, 32'h0,         1, 32'h0000_0000};
    vecs[7]  = '{0, 1, 32'h0000_000B, 32'hCAFE_F00D, 0, 32'h0000_0000};
    vecs[8]  = '{0, 0, 32'h0000_0008, 32'h0,         0, 32'hCAFE_F00D};
    vecs[9]  = '{1, 0, 32'hFFFF_FFFC, 32'h0,         1, 32'h0000_0000};
    vecs[10] = '{0, 1, 32'h0000_0010, 32'h0102_0304, 0, 32'hCAFE_F00D};
    vecs[11] = '{1, 0, 32'h0000_0010, 32'h0,         0, 32'h0102_0304};

    doReset();
    @(negedge clk);
    checkOutput("reset_ack", 32'({ack1, ack0}), 32'h0);
    checkOutput("reset_err", 32'({err1, err0}), 32'h0);
    checkOutput("reset_rdata0", rdata0, 32'h0);
    checkOutput("reset_rdata1", rdata1, 32'h0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'h0);
    monOn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);
    checkOutput("mem_word0_kept", bmem[0], 32'h0);
    checkOutput("mem_word18_untouched", bmem[18], 32'h0);
    checkOutput("mem_word2", bmem[2], 32'hCAFE_F00D);

    // Contention after reset: requester 0 first, then strict alternation.
    doReset();
    we0 = 0; addr0 = 32'h8;
    we1 = 0; addr1 = 32'h10;
    for (int k = 0; k < 6; k++)
      sb.push_back('{bit'(k % 2), 0, (k % 2) ? 32'h10 : 32'h8, 32'h0, 0,
                     (k % 2) ? 32'h0102_0304 : 32'hCAFE_F00D});
    req0 = 1; req1 = 1;
    cyc = 0; lastAck = 0; nAcks = 0; expId = 0;
    while (nAcks < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) begin
        checkOutput("rr_order", 32'(ack1), 32'(expId));
        checkOutput("rr_spacing", 32'(cyc - lastAck), 32'd3);
        lastAck = cyc;
        expId = ~expId;
        nAcks++;
      end
    end
    checkOutput("rr_ack_count", 32'(nAcks), 32'd6);
    @(posedge clk);
    #1 req0 = 0; req1 = 0;

    // Request dropped while BUSY: the access still completes exactly once.
    startAcks = ackTotal;
    sb.push_back('{0, 0, 32'h8, 32'h0, 0, 32'hCAFE_F00D});
    we0 = 0; addr0 = 32'h8; req0 = 1;
    @(posedge clk);
    #1 req0 = 0;
    repeat (8) @(negedge clk);
    checkOutput("drop_ack_count", 32'(ackTotal - startAcks), 32'd1);
    checkOutput("drop_rdata0", rdata0, 32'hCAFE_F00D);
    @(posedge clk);
    #1;

    // Reset during the BUSY cycle of a write: nothing commits, no ack.
    startAcks = ackTotal;
    we0 = 1; addr0 = 32'h4; wdata0 = 32'h1234_5678; req0 = 1;
    @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    checkOutput("reset_busy_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk);
    #1 reset = 0; req0 = 0; we0 = 0;
    @(negedge clk);
    checkOutput("midreset_rdata", rdata0 | rdata1, 32'h0);
    repeat (5) @(negedge clk);
    checkOutput("midreset_no_ack", 32'(ackTotal - startAcks), 32'd0);
    checkOutput("midreset_mem_word1", bmem[1], 32'h0);
    @(posedge clk);
    #1;
    applyStimulus('{0, 0, 32'h4, 32'h0, 0, 32'h0});
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
